// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 1440x900 mode, coordinate width,
// colour-triple type and the colour-bar edge helper.
package vga_pkg;

  localparam int COORD_W   = 11;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  localparam int H_ACTIVE_DEF = 1440;
  localparam int H_FP_DEF     = 80;
  localparam int H_SYNC_DEF   = 152;
  localparam int H_BP_DEF     = 232;

  localparam int V_ACTIVE_DEF = 900;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 28;

  localparam int COLOR_W_DEF = 4;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  // Left edge of colour bar idx (0..7) when the active width is split into eight.
  function automatic logic [COORD_W-1:0] bar_edge(input int active, input int idx);
    return COORD_W'((active * idx) / 8);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: free-running segment counter (sync, back porch, active,
// front porch) with wrap, sync and active flags decoded from the count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adv,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync_flag,
  output logic               active_flag
);

  localparam int TOTAL = SYNC + BP + ACTIVE + FP;

  if (TOTAL > COORD_MAX) begin : g_total_range
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, COORD_W);
  end
  if (ACTIVE < 1 || SYNC < 0 || BP < 0 || FP < 0) begin : g_segment_range
    $error("vga_axis_counter: invalid segment lengths");
  end

  localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] SYNC_END = COORD_W'(SYNC);
  localparam logic [COORD_W-1:0] ACT_LO   = COORD_W'(SYNC + BP);
  localparam logic [COORD_W-1:0] ACT_HI   = COORD_W'(SYNC + BP + ACTIVE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (adv) begin
      count <= wrap ? '0 : count + COORD_W'(1);
    end
  end

  assign wrap        = (count == LAST);
  assign sync_flag   = (count < SYNC_END);
  assign active_flag = (count >= ACT_LO) && (count < ACT_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters, coordinate request and one-tick
// registered pixel/sync/enable outputs. Define VGA_TEST_PATTERN_EN for pattern_sel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int COLOR_W   = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] draw_r,
  input  logic [COLOR_W-1:0] draw_g,
  input  logic [COLOR_W-1:0] draw_b,
`ifdef VGA_TEST_PATTERN_EN
  input  logic [1:0]         pattern_sel,
`endif
  output logic [COORD_W-1:0] curr_x,
  output logic [COORD_W-1:0] curr_y,
  output logic [COLOR_W-1:0] pix_r,
  output logic [COLOR_W-1:0] pix_g,
  output logic [COLOR_W-1:0] pix_b,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);

  if (COLOR_W < 1) begin : g_color_range
    $error("vga_timing_gen: COLOR_W must be at least 1");
  end

  localparam logic [COORD_W-1:0] X_OFF = COORD_W'(H_SYNC + H_BP);
  localparam logic [COORD_W-1:0] Y_OFF = COORD_W'(V_SYNC + V_BP);

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pix_t;

  logic [COORD_W-1:0] h_count;
  logic [COORD_W-1:0] v_count;
  logic               h_wrap;
  logic               v_wrap_unused;
  logic               h_sync;
  logic               v_sync;
  logic               h_active;
  logic               v_active;
  logic               active;
  pix_t               src;

  pix_t pix_p1;
  logic de_p1;
  logic hsync_p1;
  logic vsync_p1;
  logic line_start_p1;
  logic frame_start_p1;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .adv         (en),
    .count       (h_count),
    .wrap        (h_wrap),
    .sync_flag   (h_sync),
    .active_flag (h_active)
  );

  // The vertical axis steps once per completed line.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .adv         (en & h_wrap),
    .count       (v_count),
    .wrap        (v_wrap_unused),
    .sync_flag   (v_sync),
    .active_flag (v_active)
  );

  assign active = h_active & v_active;
  assign curr_x = h_active ? (h_count - X_OFF) : '0;
  assign curr_y = v_active ? (v_count - Y_OFF) : '0;

  // Stage p0: colour source selected in the same cycle as the coordinate request.
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (curr_x >= bar_edge(H_ACTIVE, k)) bar = 3'(k);
    end
  end

  // Bars run white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    src = '{r: draw_r, g: draw_g, b: draw_b};
    case (pattern_sel)
      2'd1: src = '{r: {COLOR_W{~bar[1]}}, g: {COLOR_W{~bar[2]}}, b: {COLOR_W{~bar[0]}}};
      2'd2: src = '{r: {COLOR_W{curr_x[5] ^ curr_y[5]}},
                    g: {COLOR_W{curr_x[5] ^ curr_y[5]}},
                    b: {COLOR_W{curr_x[5] ^ curr_y[5]}}};
      2'd3: src = '1;
      default: ;
    endcase
  end
`else
  assign src = '{r: draw_r, g: draw_g, b: draw_b};
`endif

  // Stage p1: every visible output registered from the same counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_p1         <= '0;
      de_p1          <= 1'b0;
      hsync_p1       <= !HSYNC_POL;
      vsync_p1       <= !VSYNC_POL;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else if (en) begin
      pix_p1         <= active ? src : '0;
      de_p1          <= active;
      hsync_p1       <= h_sync ? HSYNC_POL : !HSYNC_POL;
      vsync_p1       <= v_sync ? VSYNC_POL : !VSYNC_POL;
      line_start_p1  <= (h_count == '0);
      frame_start_p1 <= (h_count == '0) && (v_count == '0);
    end
  end

  assign pix_r       = pix_p1.r;
  assign pix_g       = pix_p1.g;
  assign pix_b       = pix_p1.b;
  assign de          = de_p1;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign line_start  = line_start_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 25x12 raster
// (hsync active-high, vsync active-low).
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;   // 25 pixels per line
  localparam int VA = 6,  VF = 1, VS = 2, VB = 3;   // 12 lines per frame
  localparam int HT = 25, VT = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [CW-1:0] draw_r, draw_g;
  logic [CW-1:0] draw_b = '0;
  logic [COORD_W-1:0] curr_x, curr_y;
  logic [CW-1:0] pix_r, pix_g, pix_b;
  logic          hsync, vsync, de, line_start, frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic [1:0]    pattern_sel = 2'd0;
`endif

  assign draw_r = curr_x[3:0];
  assign draw_g = curr_y[3:0];

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .COLOR_W (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .draw_r      (draw_r),
    .draw_g      (draw_g),
    .draw_b      (draw_b),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .curr_x      (curr_x),
    .curr_y      (curr_y),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pr, pg, pb, de, hs, vs, ls, fs, cx, cy;
  } rec_t;

  rec_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference raster position, owned by the stimulus process.
  int mh = 0, mv = 0, tick_no = 0;

  // Per-frame statistics latched by the monitor at each frame_start.
  int fr_ls = 0, fr_de = 0, fr_hs = 0, fr_vs = 0, fr_clk = 0;

  logic en_seen;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) en_seen <= 1'b0;
    else      en_seen <= en;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int xcoord(input int h);
    return (h >= 7 && h < 23) ? h - 7 : 0;
  endfunction

  function automatic int ycoord(input int v);
    return (v >= 5 && v < 11) ? v - 5 : 0;
  endfunction

  function automatic rec_t rst_rec();
    rec_t r;
    r = '{default: 0};
    r.vs = 1;
    return r;
  endfunction

  task automatic compare(input string p, input rec_t e);
    chk({p, ".pix_r"},       int'(pix_r),       e.pr);
    chk({p, ".pix_g"},       int'(pix_g),       e.pg);
    chk({p, ".pix_b"},       int'(pix_b),       e.pb);
    chk({p, ".de"},          int'(de),          e.de);
    chk({p, ".hsync"},       int'(hsync),       e.hs);
    chk({p, ".vsync"},       int'(vsync),       e.vs);
    chk({p, ".line_start"},  int'(line_start),  e.ls);
    chk({p, ".frame_start"}, int'(frame_start), e.fs);
    chk({p, ".curr_x"},      int'(curr_x),      e.cx);
    chk({p, ".curr_y"},      int'(curr_y),      e.cy);
  endtask

  // One clock of stimulus; on an en tick the expected registered outputs are queued.
  task automatic issue(input bit e);
    rec_t r;
    bit   act;
    @(negedge clk);
    en = e;
    if (e) begin
      draw_b = CW'(tick_no * 5 + 3);
      tick_no++;
      act  = (mh >= 7 && mh < 23) && (mv >= 5 && mv < 11);
      r.pr = act ? xcoord(mh) % 16 : 0;
      r.pg = act ? ycoord(mv) % 16 : 0;
      r.pb = act ? int'(draw_b) : 0;
      r.de = act ? 1 : 0;
      r.hs = (mh < 3) ? 1 : 0;
      r.vs = (mv < 2) ? 0 : 1;
      r.ls = (mh == 0) ? 1 : 0;
      r.fs = (mh == 0 && mv == 0) ? 1 : 0;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      r.cx = xcoord(mh);
      r.cy = ycoord(mv);
      sb_q.push_back(r);
    end
  endtask

  task automatic check_reset(input string p);
    compare(p, rst_rec());
  endtask

  task automatic check_frame(input string p, input int period);
    chk({p, ".frame_period"}, fr_clk, period);
    chk({p, ".line_starts"},  fr_ls,  12);
    chk({p, ".de_ticks"},     fr_de,  96);
    chk({p, ".hsync_ticks"},  fr_hs,  36);
    chk({p, ".vsync_ticks"},  fr_vs,  50);
  endtask

  initial begin : monitor
    rec_t e, last;
    int   cyc, fs_cyc, nfs, acc_ls, acc_de, acc_hs, acc_vs;
    cyc = 0; fs_cyc = 0; nfs = 0;
    acc_ls = 0; acc_de = 0; acc_hs = 0; acc_vs = 0;
    last = rst_rec();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        last = rst_rec();
        nfs = 0;
        acc_ls = 0; acc_de = 0; acc_hs = 0; acc_vs = 0;
      end else if (en_seen) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          compare("tick", e);
          last = e;
          if (frame_start) begin
            if (nfs > 0) begin
              fr_ls = acc_ls; fr_de = acc_de; fr_hs = acc_hs; fr_vs = acc_vs;
              fr_clk = cyc - fs_cyc;
            end
            nfs++;
            fs_cyc = cyc;
            acc_ls = 0; acc_de = 0; acc_hs = 0; acc_vs = 0;
          end
          acc_ls += int'(line_start);
          acc_de += int'(de);
          acc_hs += int'(hsync == 1'b1);
          acc_vs += int'(vsync == 1'b0);
        end
      end else begin
        compare("hold", last);
      end
    end
  end

  initial begin : stimulus
    #1 rst = 1'b0;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    repeat (2 * HT * VT + 5) issue(1'b1);
    issue(1'b0); issue(1'b0);
    check_frame("continuous", 300);

    for (int i = 0; i < 1500; i++) issue((i % 4 == 0) || (i % 4 == 3));
    issue(1'b0); issue(1'b0);
    check_frame("stalled", 600);

    while (!(mh == 10 && mv == 5)) issue(1'b1);
    issue(1'b0);
    chk("pre_reset.de", int'(de), 1);
    #2 rst = 1'b0;
    #1 check_reset("mid_reset");
    mh = 0; mv = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    repeat (2 * HT * VT + 5) issue(1'b1);
    issue(1'b0); issue(1'b0);
    check_frame("after_reset", 300);

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish t=%0t", $time);
    $fatal(1, "bench timed out");
  end

endmodule
